// File: rtl/byte_select_register.sv
`default_nettype none
// ============================================================================
//  Module      : byte_select_register
//  Description : Wide storage register made of ADDR_WIDTH slots of DATA_WIDTH
//                bits, written and read one slot at a time through
//                i_byte_sel. The whole contents are always visible in
//                parallel on o_full_data. Intended for byte-serial CPU buses
//                that program wide per-line control vectors (e.g. interrupt
//                enable / edge-type masks).
//  Ports       :
//      i_clk        - clock; all state updates on the rising edge
//      i_reset      - asynchronous active-low reset; clears every slot
//      i_write      - write strobe for the selected slot
//      i_byte_sel   - slot index for writes and for the o_data read
//      i_data       - write data
//      o_data       - contents of slot i_byte_sel (combinational)
//      o_full_data  - all slots, slot k on [k*DATA_WIDTH +: DATA_WIDTH]
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_select_register #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_W      = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_write,
    input  logic [SEL_W-1:0]                 i_byte_sel,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [DATA_WIDTH*ADDR_WIDTH-1:0] o_full_data
);

    logic [DATA_WIDTH-1:0] r_slot [ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] w_data;

    // Slot decoding compares the select against every legal index. A select
    // value >= ADDR_WIDTH matches no slot, so such writes are dropped and the
    // read mux falls through to zero without a separate range check.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < ADDR_WIDTH; k++) begin
                r_slot[k] <= '0;
            end
        end else if (i_write) begin
            for (int k = 0; k < ADDR_WIDTH; k++) begin
                if (i_byte_sel == SEL_W'(k)) begin
                    r_slot[k] <= i_data;
                end
            end
        end
    end

    // Read path shows stored contents only: during a write cycle the old
    // value is visible until the clock edge (no write-through bypass).
    always_comb begin
        w_data = '0;
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            if (i_byte_sel == SEL_W'(k)) begin
                w_data = r_slot[k];
            end
        end
    end

    assign o_data = w_data;

    generate
        for (genvar g = 0; g < ADDR_WIDTH; g++) begin : g_pack
            assign o_full_data[g*DATA_WIDTH +: DATA_WIDTH] = r_slot[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_byte_select_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_select_register
//  Description : Scoreboard bench for byte_select_register. Stimulus pushes
//                expected outputs taken from a byte-array reference model;
//                an independent monitor pops and compares on each sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_select_register;

    localparam int c_dw    = 8;
    localparam int c_aw    = 32;
    localparam int c_sel_w = 5;

    logic                    clk;
    logic                    i_reset;
    logic                    i_write;
    logic [c_sel_w-1:0]      i_byte_sel;
    logic [c_dw-1:0]         i_data;
    logic [c_dw-1:0]         o_data;
    logic [c_dw*c_aw-1:0]    o_full_data;

    byte_select_register #(
        .DATA_WIDTH (c_dw),
        .ADDR_WIDTH (c_aw)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_write     (i_write),
        .i_byte_sel  (i_byte_sel),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_full_data (o_full_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_dw-1:0]      d;
        logic [c_dw*c_aw-1:0] f;
        string                name;
    } exp_t;

    exp_t       q_exp [$];
    event       ev_sample;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pops  = 0;
    int         n_push  = 0;

    // Reference model: plain byte array, one entry per slot.
    byte unsigned model [c_aw];

    // Expected response from current model and current select.
    task automatic check(input string name);
        exp_t e;
        e.name = name;
        e.d = (int'(i_byte_sel) < c_aw) ? model[i_byte_sel] : 8'h00;
        e.f = '0;
        for (int k = 0; k < c_aw; k++) e.f[k*c_dw +: c_dw] = model[k];
        q_exp.push_back(e);
        n_push++;
        -> ev_sample;
        #1;
    endtask

    // Monitor: samples DUT outputs whenever a sample is announced.
    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            n_tests++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: sample with no expected entry");
            end else begin
                e = q_exp.pop_front();
                n_pops++;
                if (o_data !== e.d) begin
                    n_fail++;
                    $display("FAIL %s o_data: got %02h expected %02h (sel=%0d)", e.name, o_data, e.d, i_byte_sel);
                end
                n_tests++;
                if (o_full_data !== e.f) begin
                    n_fail++;
                    $display("FAIL %s o_full_data: got %064h expected %064h", e.name, o_full_data, e.f);
                end
            end
        end
    end

    // One bus cycle: drive after the falling edge, check before the rising
    // edge (old contents), update the model at the edge, check after it.
    task automatic cyc(input logic w, input int sel, input logic [7:0] data, input string name);
        @(negedge clk);
        i_write    = w;
        i_byte_sel = c_sel_w'(sel);
        i_data     = data;
        #1 check({name, "_pre"});
        @(posedge clk);
        if (i_reset && w && sel < c_aw) model[sel] = data;
        #1 check({name, "_post"});
    endtask

    task automatic read_sel(input int sel, input string name);
        i_byte_sel = c_sel_w'(sel);
        #1 check(name);
    endtask

    initial begin
        logic [7:0] d;
        int         s;
        i_reset = 1'b0; i_write = 1'b0; i_byte_sel = '0; i_data = '0;
        for (int k = 0; k < c_aw; k++) model[k] = 8'h00;
        repeat (2) @(posedge clk);
        #2 check("reset_state");
        @(negedge clk);
        i_reset = 1'b1;

        // Preload, then reset asynchronously between edges.
        cyc(1'b1, 3, 8'h11, "preload3");
        cyc(1'b1, 20, 8'h22, "preload20");
        @(negedge clk);
        i_write = 1'b0;
        #2 i_reset = 1'b0;
        for (int k = 0; k < c_aw; k++) model[k] = 8'h00;
        #1 check("async_reset");
        @(negedge clk);
        i_reset = 1'b1;

        // Single write.
        cyc(1'b1, 5, 8'hA5, "single_write");
        @(negedge clk); i_write = 1'b0;
        read_sel(5, "single_read5");

        // Walk all slots, then read back.
        for (int k = 0; k < c_aw; k++) cyc(1'b1, k, 8'(k + 1), "walk");
        @(negedge clk); i_write = 1'b0;
        for (int k = 0; k < c_aw; k++) read_sel(k, "walk_read");

        // Hold: no write with junk data.
        for (int k = 0; k < c_aw; k++) cyc(1'b0, k, 8'hFF, "hold");

        // Overwrite and read timing on the top slot.
        cyc(1'b1, 31, 8'h3C, "ovw_first");
        cyc(1'b1, 31, 8'hC3, "ovw_second");

        // Mid-sequence reset with a write in flight.
        for (int k = 0; k < 4; k++) cyc(1'b1, k, 8'(8'h50 + k), "mid_pre");
        @(negedge clk);
        i_write = 1'b1; i_byte_sel = 5'd4; i_data = 8'h77;
        #1 i_reset = 1'b0;
        for (int k = 0; k < c_aw; k++) model[k] = 8'h00;
        #1 check("mid_reset_async");
        @(posedge clk);
        #1 check("mid_reset_inflight");
        @(negedge clk);
        i_write = 1'b0;
        i_reset = 1'b1;
        read_sel(4, "mid_reset_slot4");

        // Randomized traffic with back-to-back writes.
        for (int n = 0; n < 300; n++) begin
            s = $urandom_range(c_aw - 1);
            d = 8'($urandom);
            cyc(($urandom_range(3) != 0), s, d, "rand");
            if ($urandom_range(3) == 0) begin
                read_sel($urandom_range(c_aw - 1), "rand_read");
            end
        end

        // Drain the scoreboard within a bounded time.
        for (int t = 0; t < 100 && q_exp.size() != 0; t++) #1;
        n_tests++;
        if (q_exp.size() != 0 || n_pops != n_push) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, %0d popped of %0d pushed", q_exp.size(), n_pops, n_push);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
